// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman decode path: controller state
// encoding and the dictionary-miss character value.
package huff_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } ctrl_state_t;

    localparam logic [7:0] DICT_MISS = 8'h00;

    // A controller is busy only while it owns the memory port or the walker.
    function automatic logic state_is_active(input logic [2:0] s);
        return (s == FETCH) || (s == SHIFT) || (s == WRITE);
    endfunction

endpackage

// File: rtl/huff_decode_ctrl_if.sv
// Memory port and tree-walker handshake shared by the decode controller
// (master) and the memory/walker side (slave).
interface huff_decode_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    logic              walk_clr;
    logic              bit_valid;
    logic              bit_out;
    logic              bit_ready;
    logic              char_valid;
    logic [7:0]        char_in;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, walk_clr, bit_valid, bit_out,
        input  mem_rdata, mem_ack, bit_ready, char_valid, char_in
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, walk_clr, bit_valid, bit_out,
        output mem_rdata, mem_ack, bit_ready, char_valid, char_in
    );
endinterface

// File: rtl/huff_bit_serializer.sv
// Byte-wide shift register that hands compressed bits to the walker MSB-first
// and tracks how many bits of the current byte are still unsent.
module huff_bit_serializer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       msb,
    output logic       empty,
    output logic       last
);

    logic [7:0] shreg;
    logic [3:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= 4'd8;
        end else if (shift) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
        end
    end

    assign msb   = shreg[7];
    assign empty = (bit_cnt == 4'd0);
    assign last  = (bit_cnt == 4'd1);

endmodule

// File: rtl/huff_decode_ctrl.sv
// Huffman decode sequencer: fetches compressed bytes, feeds the tree walker
// bit by bit and writes decoded characters back through one memory port.
module huff_decode_ctrl
    import huff_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [CNT_W-1:0]    char_total,
    huff_decode_ctrl_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                dict_error,
    output logic [CNT_W-1:0]    out_count
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_FETCH = 3'(FETCH);
    localparam logic [2:0] S_SHIFT = 3'(SHIFT);
    localparam logic [2:0] S_WRITE = 3'(WRITE);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam logic [2:0] S_ERR   = 3'(ERR);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [7:0]        wr_char;
    logic              walk_clr_q;

    logic start_ok;
    logic bit_hs;
    logic rd_done;
    logic ser_msb;
    logic ser_empty;
    logic ser_last;

    assign start_ok = start && ((state == S_IDLE) || (state == S_ERR));
    assign bit_hs   = (state == S_SHIFT) && bus.bit_ready;
    assign rd_done  = (state == S_FETCH) && bus.mem_ack;

    huff_bit_serializer u_ser (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       (start_ok),
        .load      (rd_done),
        .load_data (bus.mem_rdata),
        .shift     (bit_hs),
        .msb       (ser_msb),
        .empty     (ser_empty),
        .last      (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            out_cnt_q  <= '0;
            wr_char    <= '0;
            walk_clr_q <= 1'b0;
        end else begin
            walk_clr_q <= start_ok;
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        src_ptr   <= src_base;
                        dst_ptr   <= dst_base;
                        remaining <= char_total;
                        out_cnt_q <= '0;
                        state     <= (char_total == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        src_ptr <= src_ptr + 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                // A completed code wins over running out of bits in the byte.
                S_SHIFT: begin
                    if (bus.bit_ready) begin
                        if (bus.char_valid) begin
                            if (bus.char_in == DICT_MISS) begin
                                state <= S_ERR;
                            end else begin
                                wr_char <= bus.char_in;
                                state   <= S_WRITE;
                            end
                        end else if (ser_last) begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        dst_ptr   <= dst_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        out_cnt_q <= out_cnt_q + 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= S_DONE;
                        end else if (ser_empty) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = (state == S_FETCH) || (state == S_WRITE);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = (state == S_FETCH) ? src_ptr :
                           (state == S_WRITE) ? dst_ptr : '0;
    assign bus.mem_wdata = (state == S_WRITE) ? wr_char : 8'h00;
    assign bus.walk_clr  = walk_clr_q;
    assign bus.bit_valid = (state == S_SHIFT);
    assign bus.bit_out   = ser_msb;

    assign busy       = state_is_active(state);
    assign done       = (state == S_DONE);
    assign dict_error = (state == S_ERR);
    assign out_count  = out_cnt_q;

endmodule

// File: tb/tb_huff_decode_ctrl.sv
// Randomised scoreboard bench: a code-table reference model predicts memory
// traffic, and a memory/walker responder checks every access and bit.
module tb_huff_decode_ctrl;
    import huff_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int CNT_W     = 16;
    localparam int MAX_CODES = 64;
    localparam int BUDGET    = 4000;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [CNT_W-1:0]  char_total = '0;
    logic              busy;
    logic              done;
    logic              dict_error;
    logic [CNT_W-1:0]  out_count;

    huff_decode_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    huff_decode_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .char_total (char_total),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .dict_error (dict_error),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          n_codes = 0;
    int          code_len  [MAX_CODES];
    logic [15:0] code_bits [MAX_CODES];
    logic [7:0]  code_char [MAX_CODES];
    logic [15:0] exp_rd_q [$];
    logic [23:0] exp_wr_q [$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int pick_delay();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 1;
            2:       return 5;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic set_code(input int i, input int len, input logic [15:0] bits, input logic [7:0] ch);
        code_len[i]  = len;
        code_bits[i] = bits;
        code_char[i] = ch;
    endtask

    // Reference model: pack the code stream into memory, then predict reads and writes.
    task automatic build_model(input logic [15:0] src, input logic [15:0] dst, input int n,
                               output bit exp_err, output int exp_count);
        int bitpos;
        int consumed;
        logic [15:0] a;
        bitpos = 0;
        consumed = 0;
        exp_err = 1'b0;
        exp_count = 0;
        for (int k = 0; k < MAX_CODES; k++) mem[16'(src + 16'(k))] = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = code_len[i] - 1; b >= 0; b--) begin
                a = 16'(src + 16'(bitpos / 8));
                mem[a][3'(7 - (bitpos % 8))] = code_bits[i][4'(b)];
                bitpos++;
            end
        end
        for (int i = 0; i < n; i++) begin
            consumed += code_len[i];
            if (code_char[i] == DICT_MISS) begin
                exp_err = 1'b1;
                break;
            end
            exp_wr_q.push_back({16'(dst + 16'(i)), code_char[i]});
            exp_count++;
        end
        for (int k = 0; k < (consumed + 7) / 8; k++) exp_rd_q.push_back(16'(src + 16'(k)));
    endtask

    // Memory and walker responder; also the scoreboard monitor for memory traffic.
    int          code_idx = 0;
    int          bits_seen = 0;
    logic        txn_active = 1'b0;
    logic        txn_we;
    logic [15:0] txn_addr;
    logic [7:0]  txn_data;
    int          wait_left;
    logic [15:0] cb;
    logic [23:0] wr_exp;
    logic [15:0] rd_exp;

    always @(negedge clk) begin
        bus.mem_ack    = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        bus.bit_ready  = 1'b0;
        bus.mem_rdata  = 8'($urandom);
        if (!n_rst) begin
            txn_active = 1'b0;
            code_idx   = 0;
            bits_seen  = 0;
        end else begin
            if (bus.walk_clr) begin
                code_idx  = 0;
                bits_seen = 0;
            end
            bus.bit_ready = ($urandom_range(0, 3) != 0);
            if (bus.bit_valid && bus.bit_ready) begin
                checkOutput("walker_codes_left", 32'(code_idx < n_codes), 1);
                if (code_idx < n_codes) begin
                    cb = code_bits[code_idx];
                    checkOutput("bit_out", bus.bit_out, cb[4'(code_len[code_idx] - 1 - bits_seen)]);
                    bits_seen++;
                    if (bits_seen == code_len[code_idx]) begin
                        bus.char_valid = 1'b1;
                        bus.char_in    = code_char[code_idx];
                        code_idx++;
                        bits_seen = 0;
                    end
                end
            end
            if (txn_active) begin
                checkOutput("req_stable", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                            {1'b1, txn_we, txn_addr, txn_data});
                if (!bus.mem_req) txn_active = 1'b0;
            end else if (bus.mem_req) begin
                txn_active = 1'b1;
                txn_we     = bus.mem_we;
                txn_addr   = bus.mem_addr;
                txn_data   = bus.mem_wdata;
                wait_left  = pick_delay();
                req_count++;
            end
            if (txn_active) begin
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    txn_active  = 1'b0;
                    if (txn_we) begin
                        checkOutput("write_pending", 32'(exp_wr_q.size() != 0), 1);
                        if (exp_wr_q.size() != 0) begin
                            wr_exp = exp_wr_q.pop_front();
                            checkOutput("write_addr_data", {txn_addr, txn_data}, wr_exp);
                        end
                    end else begin
                        checkOutput("read_pending", 32'(exp_rd_q.size() != 0), 1);
                        if (exp_rd_q.size() != 0) begin
                            rd_exp = exp_rd_q.pop_front();
                            checkOutput("read_addr", txn_addr, rd_exp);
                        end
                        bus.mem_rdata = mem[txn_addr];
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] src, input logic [15:0] dst, input int n, input bit inject);
        bit exp_err;
        int exp_count;
        int reqs_before;
        int cycles;
        build_model(src, dst, n, exp_err, exp_count);
        n_codes = n;
        @(negedge clk); #1;
        reqs_before = req_count;
        src_base   = src;
        dst_base   = dst;
        char_total = 16'(n);
        start      = 1'b1;
        @(negedge clk); #1;
        start      = 1'b0;
        src_base   = 16'($urandom);
        dst_base   = 16'($urandom);
        char_total = 16'($urandom_range(1, 20));
        cycles = 0;
        while (cycles < BUDGET && !(done || dict_error)) begin
            start = inject && (cycles == 6);
            @(negedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        checkOutput("finished_in_budget", 32'(cycles < BUDGET), 1);
        checkOutput("outcome_err", dict_error, exp_err);
        checkOutput("outcome_done", done, !exp_err);
        checkOutput("out_count", out_count, exp_count);
        checkOutput("busy_at_end", busy, 0);
        if (n == 0) begin
            checkOutput("zero_done_latency", cycles, 0);
            checkOutput("zero_no_mem", req_count - reqs_before, 0);
        end
        if (!exp_err) begin
            @(negedge clk); #1;
            checkOutput("done_one_cycle", done, 0);
        end else begin
            repeat (3) @(negedge clk);
            #1;
            checkOutput("dict_error_held", dict_error, 1);
            checkOutput("busy_in_err", busy, 0);
        end
        checkOutput("reads_left", exp_rd_q.size(), 0);
        checkOutput("writes_left", exp_wr_q.size(), 0);
    endtask

    task automatic reset_in_write();
        bit exp_err;
        int exp_count;
        int cycles;
        for (int i = 0; i < 3; i++) set_code(i, 4, 16'($urandom), 8'($urandom_range(1, 255)));
        build_model(16'h4000, 16'h5000, 3, exp_err, exp_count);
        n_codes = 3;
        @(negedge clk); #1;
        src_base = 16'h4000; dst_base = 16'h5000; char_total = 16'd3; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (cycles < BUDGET && !(bus.mem_req && bus.mem_we)) begin
            @(negedge clk); #1;
            cycles++;
        end
        checkOutput("reached_write", 32'(bus.mem_req && bus.mem_we), 1);
        n_rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_in_write_outputs",
                    {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.walk_clr,
                     bus.bit_valid, bus.bit_out, busy, done, dict_error}, 0);
        checkOutput("reset_in_write_count", out_count, 0);
        n_rst = 1'b1;
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests_failed=%0d", tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.walk_clr,
                     bus.bit_valid, bus.bit_out, busy, done, dict_error}, 0);
        checkOutput("reset_out_count", out_count, 0);
        n_rst = 1'b1;

        // Single 3-bit code in byte A0, remaining five bits dropped.
        set_code(0, 3, 16'b101, 8'h41);
        applyStimulus(16'h0100, 16'h2000, 1, 1'b0);

        // Three 5-bit codes straddling a byte boundary.
        for (int i = 0; i < 3; i++) set_code(i, 5, 16'($urandom), 8'(8'h61 + 8'(i)));
        applyStimulus(16'h1000, 16'h3000, 3, 1'b0);

        // Dictionary miss on the second character, then restart from ERR.
        set_code(0, 6, 16'($urandom), 8'h11);
        set_code(1, 4, 16'($urandom), DICT_MISS);
        set_code(2, 5, 16'($urandom), 8'h22);
        applyStimulus(16'h0200, 16'h0300, 3, 1'b0);
        for (int i = 0; i < 4; i++) set_code(i, $urandom_range(1, 12), 16'($urandom), 8'($urandom_range(1, 255)));
        applyStimulus(16'h0A00, 16'h0B00, 4, 1'b0);

        // Zero characters, then a stray start while busy.
        applyStimulus(16'h0700, 16'h0800, 0, 1'b0);
        for (int i = 0; i < 6; i++) set_code(i, $urandom_range(3, 12), 16'($urandom), 8'($urandom_range(1, 255)));
        applyStimulus(16'h0C00, 16'h0D00, 6, 1'b1);

        // Code completing on the 8th bit, destination wrapping past FFFF.
        set_code(0, 8, 16'($urandom), 8'h5A);
        set_code(1, 5, 16'($urandom), 8'h6B);
        set_code(2, 3, 16'($urandom), 8'h7C);
        applyStimulus(16'h0E00, 16'hFFFF, 3, 1'b0);

        reset_in_write();

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) set_code(i, $urandom_range(1, 12), 16'($urandom), 8'($urandom_range(1, 255)));
            applyStimulus(16'($urandom), 16'($urandom), n, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
